// File: rtl/qam_demod.sv
// Coherent 4-QAM demodulator: mix, integrate-and-dump, sign slicer.
// Define QAM_DEMOD_SAT_EN for saturating accumulators (default: wrap).
module qam_demod #(
  parameter int SYMBOL_LEN = 16,
  parameter int ACC_W      = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic                    sym_start,
  input  logic signed [7:0]       signal_in,
  input  logic signed [7:0]       sin_in,
  input  logic signed [7:0]       cos_in,
  output logic [1:0]              data_out,
  output logic                    data_valid,
  output logic signed [ACC_W-1:0] i_acc,
  output logic signed [ACC_W-1:0] q_acc
);

  localparam int CNT_W = $clog2(SYMBOL_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMBOL_LEN);

  typedef enum logic [1:0] {
    IDLE,
    INTEG,
    DUMP
  } state_t;

  logic signed [15:0]      pi_q, pi_d, pq_q, pq_d;
  logic                    pv_q, pv_d, ps_q, ps_d;
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] iacc_q, iacc_d, qacc_q, qacc_d;
  logic signed [ACC_W-1:0] i_acc_q, i_acc_d, q_acc_q, q_acc_d;
  logic [1:0]              data_out_q, data_out_d;
  logic                    data_valid_q, data_valid_d;

  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [15:0]      p
  );
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(a) + (ACC_W+1)'(p);
`ifdef QAM_DEMOD_SAT_EN
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                      : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
    return s[ACC_W-1:0];
  endfunction

  always_comb begin
    pv_d = sample_valid;
    ps_d = sym_start && sample_valid;
    pi_d = pi_q;
    pq_d = pq_q;
    if (sample_valid) begin
      pi_d = 16'(signal_in) * 16'(cos_in);
      pq_d = 16'(signal_in) * 16'(sin_in);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    iacc_d       = iacc_q;
    qacc_d       = qacc_q;
    i_acc_d      = i_acc_q;
    q_acc_d      = q_acc_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pv_q && ps_q) begin
          iacc_d  = ACC_W'(pi_q);
          qacc_d  = ACC_W'(pq_q);
          cnt_d   = CNT_W'(1);
          state_d = INTEG;
        end
      end
      INTEG: begin
        if (pv_q && ps_q) begin
          // re-alignment: drop the partial window
          iacc_d = ACC_W'(pi_q);
          qacc_d = ACC_W'(pq_q);
          cnt_d  = CNT_W'(1);
        end else if (pv_q) begin
          iacc_d = acc_add(iacc_q, pi_q);
          qacc_d = acc_add(qacc_q, pq_q);
          cnt_d  = cnt_q + 1'b1;
          if (cnt_d == LAST) state_d = DUMP;
        end
      end
      DUMP: begin
        i_acc_d      = iacc_q;
        q_acc_d      = qacc_q;
        data_out_d   = {~iacc_q[ACC_W-1], ~qacc_q[ACC_W-1]};
        data_valid_d = 1'b1;
        cnt_d        = '0;
        state_d      = IDLE;
        if (pv_q && ps_q) begin
          iacc_d  = ACC_W'(pi_q);
          qacc_d  = ACC_W'(pq_q);
          cnt_d   = CNT_W'(1);
          state_d = INTEG;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pi_q         <= '0;
      pq_q         <= '0;
      pv_q         <= 1'b0;
      ps_q         <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      iacc_q       <= '0;
      qacc_q       <= '0;
      i_acc_q      <= '0;
      q_acc_q      <= '0;
      data_out_q   <= 2'b00;
      data_valid_q <= 1'b0;
    end else begin
      pi_q         <= pi_d;
      pq_q         <= pq_d;
      pv_q         <= pv_d;
      ps_q         <= ps_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      iacc_q       <= iacc_d;
      qacc_q       <= qacc_d;
      i_acc_q      <= i_acc_d;
      q_acc_q      <= q_acc_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign i_acc      = i_acc_q;
  assign q_acc      = q_acc_q;

endmodule

// File: doc/qam_demod.md
# qam_demod

Coherent QAM (4-QAM / QPSK) demodulator: the receive-side counterpart of `qam_mixer`. It multiplies an incoming signed 8-bit passband sample stream by locally generated `cos_in`/`sin_in` carrier samples from the `sin_cos` generator. It integrates each product over one symbol window (integrate-and-dump) and slices the two accumulator signs back into the 2-bit symbol that `qam_mixer` transmitted. It sits between the channel/ADC sample path and the bit sink.

## Interface
- `SYMBOL_LEN`, default 16: accepted samples per symbol window (≥2).
- `ACC_W`, default 24: signed accumulator width (must be ≥ 16 + clog2(SYMBOL_LEN)).
- `clk` input 1: the single clock for all logic.
- `rst` input 1: reset, asynchronous, active-low.
- `sample_valid` input 1: `signal_in`/`sin_in`/`cos_in` are valid this cycle.
- `sym_start` input 1: symbol-boundary pulse; the sample presented with it is the first of a window.
- `signal_in` input 8 signed: received passband sample.
- `sin_in` input 8 signed: local quadrature carrier sample.
- `cos_in` input 8 signed: local in-phase carrier sample.
- `data_out` output 2: recovered symbol; [1] = I bit, [0] = Q bit.
- `data_valid` output 1: one-cycle strobe; `data_out` is new this cycle.
- `i_acc`, `q_acc` output ACC_W signed: the last dumped accumulator values, held with `data_out`.

## Operation
- Symbol mapping matches `qam_mixer`: bit = 1 ⇔ the carrier is transmitted with positive sign. Decision: `data_out[1] = (i_acc >= 0)`, `data_out[0] = (q_acc >= 0)`. A zero accumulator decides 1.
- Stage 1 (product): when `sample_valid` is high, register `pi = signal_in*cos_in` and `pq = signal_in*sin_in` as 16-bit signed, plus flag `pv`. Register a copy of `sym_start && sample_valid` as `ps`.
- Stage 2 (integrate), FSM states:
  - IDLE: wait. When `pv && ps`, load the accumulators with `pi`/`pq`, set `cnt=1`, and go to INTEG.
  - INTEG: on each `pv`, add the sign-extended `pi`/`pq` and increment `cnt`. When `cnt` reaches SYMBOL_LEN, go to DUMP.
  - DUMP: register `i_acc`, `q_acc` and `data_out`, pulse `data_valid`, clear `cnt`. Return to IDLE, or to INTEG if this cycle carries `pv && ps` (back-to-back windows lose no sample; that sample seeds the new accumulation).
- `pv && ps` while in INTEG with `cnt < SYMBOL_LEN`: discard the partial window with no `data_valid`, and reload from this product (`cnt=1`) as a re-alignment.
- `sample_valid` low: the pipeline holds; the FSM does not advance; gaps of any length are allowed.
- Asynchronous reset mid-window discards everything; no `data_valid` follows reset until a full new window completes.

## Timing
- Reset values: `data_out=2'b00`, `data_valid=0`, `i_acc=0`, `q_acc=0`, FSM=IDLE, `cnt=0`, `pv=0`, `ps=0`.
- Latency: the last sample of a window is sampled at edge E; its product is registered at E; it is accumulated at E+1; DUMP registers outputs at E+2. `data_valid` is high for exactly one cycle after E+2.
- `data_out`, `i_acc` and `q_acc` hold their values until the next DUMP.
- Throughput: one sample per clock; continuous windows produce one `data_valid` every SYMBOL_LEN cycles.

## Configuration
- `QAM_DEMOD_SAT_EN` defined: accumulator adds saturate to ±(2^(ACC_W-1)-1 / -2^(ACC_W-1)); decision signs stay correct under overflow.
- `QAM_DEMOD_SAT_EN` undefined: accumulators wrap modulo 2^ACC_W (two's complement); the sizing rule on ACC_W guarantees no overflow for legal SYMBOL_LEN.

## Test plan
- Reset: hold `rst=0` with random inputs → all outputs 0, no `data_valid`. Release and idle → still no `data_valid`.
- SYMBOL_LEN=4, `cos_in=64`, `sin_in=0`, `signal_in=64`, `sym_start` on sample 0 → one `data_valid` 3 edges after sample 3, with `i_acc=16384`, `q_acc=0`, `data_out=2'b11`. Repeat with `signal_in=-64` → `i_acc=-16384`, `data_out=2'b01`.
- Loopback: `sin_cos` → `qam_mixer` → `qam_demod` with SYMBOL_LEN equal to one carrier period and data cycling 0..3 → `data_out` sequence 0,1,2,3 matches with zero errors.
- Gaps and re-sync: deassert `sample_valid` for 5 cycles mid-window → same result as the gapless run. Assert `sym_start` at sample 2 of a window → no output for the partial window; the next output covers samples from the new `sym_start`.
- Back-to-back: `sym_start` every 4 valid samples, continuous → `data_valid` every 4 cycles, no dropped samples.
- Overflow: ACC_W=16, SYMBOL_LEN=4, `signal_in=cos_in=-128` → `i_acc=32767` with `QAM_DEMOD_SAT_EN`, `i_acc=0` (wrapped 65536) without.
